// File: rtl/vde_pkg.sv
// rtl/vde_pkg.sv - shared widths and packer state encoding for the vde decision engine
package vde_pkg;

  localparam int VDE_BATCH_MAX = 8;
  localparam int VDE_CNT_W     = 4;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_EMIT    = 2'd1,
    ST_DECAY   = 2'd2
  } bump_pack_state_e;

endpackage

// File: rtl/vde_bump_packer.sv
// rtl/vde_bump_packer.sv - packs learned-clause literals into vde multi-bump batches plus a decay pulse
// Optional VDE_BUMP_DEDUP_EN: drop literals already present in the current batch.
module vde_bump_packer
  import vde_pkg::*;
#(
  parameter int BATCH  = 8,
  parameter int DROP_W = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 clear_all,
  input  logic [31:0]                          max_var,
  input  logic                                 lit_valid,
  output logic                                 lit_ready,
  input  logic [31:0]                          lit_var,
  input  logic                                 lit_last,
  input  logic                                 bump_ready,
  output logic [VDE_CNT_W-1:0]                 bump_count,
  output logic [VDE_BATCH_MAX-1:0][31:0]       bump_vars,
  output logic                                 decay,
  output logic                                 busy,
  output logic [DROP_W-1:0]                    drop_cnt
);

  localparam logic [VDE_CNT_W-1:0] BATCH_N = VDE_CNT_W'(BATCH);

  bump_pack_state_e                      state_q, state_d;
  logic [VDE_CNT_W-1:0]                  n_q, n_d;
  logic [VDE_BATCH_MAX-1:0][31:0]        batch_q, batch_d;
  logic                                  pending_decay_q, pending_decay_d;
  logic [DROP_W-1:0]                     drop_cnt_q, drop_cnt_d;
  logic                                  lit_illegal;
  logic                                  lit_dup;

  assign lit_illegal = (lit_var == 32'd0) || (lit_var > max_var);

  always_comb begin
    lit_dup = 1'b0;
`ifdef VDE_BUMP_DEDUP_EN
    for (int i = 0; i < BATCH; i++) begin
      if ((VDE_CNT_W'(i) < n_q) && (batch_q[i] == lit_var)) lit_dup = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d         = state_q;
    n_d             = n_q;
    batch_d         = batch_q;
    pending_decay_d = pending_decay_q;
    drop_cnt_d      = drop_cnt_q;
    lit_ready       = 1'b0;
    bump_count      = '0;
    bump_vars       = '0;
    decay           = 1'b0;

    case (state_q)
      ST_COLLECT: begin
        lit_ready = 1'b1;
        if (lit_valid) begin
          if (lit_illegal) begin
            if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
          end else if (!lit_dup) begin
            for (int i = 0; i < BATCH; i++) begin
              if (VDE_CNT_W'(i) == n_q) batch_d[i] = lit_var;
            end
            n_d = n_q + 1'b1;
          end
          // An empty final batch skips EMIT so decay still follows the clause.
          if (lit_last) begin
            pending_decay_d = 1'b1;
            state_d         = (n_d != '0) ? ST_EMIT : ST_DECAY;
          end else if (n_d == BATCH_N) begin
            state_d = ST_EMIT;
          end
        end
      end
      ST_EMIT: begin
        if (bump_ready) begin
          bump_count = n_q;
          bump_vars  = batch_q;
          n_d        = '0;
          batch_d    = '0;
          state_d    = pending_decay_q ? ST_DECAY : ST_COLLECT;
        end
      end
      ST_DECAY: begin
        if (bump_ready) begin
          decay           = 1'b1;
          pending_decay_d = 1'b0;
          state_d         = ST_COLLECT;
        end
      end
      default: state_d = ST_COLLECT;
    endcase

    if (clear_all) begin
      state_d         = ST_COLLECT;
      n_d             = '0;
      batch_d         = '0;
      pending_decay_d = 1'b0;
      drop_cnt_d      = drop_cnt_q;
      lit_ready       = 1'b0;
      bump_count      = '0;
      bump_vars       = '0;
      decay           = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_COLLECT;
      n_q             <= '0;
      batch_q         <= '0;
      pending_decay_q <= 1'b0;
      drop_cnt_q      <= '0;
    end else begin
      state_q         <= state_d;
      n_q             <= n_d;
      batch_q         <= batch_d;
      pending_decay_q <= pending_decay_d;
      drop_cnt_q      <= drop_cnt_d;
    end
  end

  assign busy     = (state_q != ST_COLLECT) || (n_q != '0);
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_vde_bump_packer.sv
// tb/tb_vde_bump_packer.sv - self-checking bench for vde_bump_packer (directed clauses plus random traffic)
module tb_vde_bump_packer;

`ifdef VDE_BUMP_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  typedef struct packed {
    logic            dec;
    logic [3:0]      cnt;
    logic [7:0][31:0] vars;
  } ev_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             clear_all;
  logic [31:0]      max_var;
  logic             lit_valid;
  logic             lit_ready;
  logic [31:0]      lit_var;
  logic             lit_last;
  logic             bump_ready;
  logic [3:0]       bump_count;
  logic [7:0][31:0] bump_vars;
  logic             decay;
  logic             busy;
  logic [15:0]      drop_cnt;

  vde_bump_packer dut (
    .clk        (clk),
    .reset      (reset),
    .clear_all  (clear_all),
    .max_var    (max_var),
    .lit_valid  (lit_valid),
    .lit_ready  (lit_ready),
    .lit_var    (lit_var),
    .lit_last   (lit_last),
    .bump_ready (bump_ready),
    .bump_count (bump_count),
    .bump_vars  (bump_vars),
    .decay      (decay),
    .busy       (busy),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  int  cyc = 0;
  int  n_chk = 0;
  int  n_pass = 0;
  int  exp_drops = 0;
  int  acc_cyc = 0;
  ev_t exp_q[$];
  ev_t obs_q[$];
  int  obs_cyc_q[$];
  ev_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && (bump_count != 4'd0 || decay)) begin
      mon_e.dec  = decay;
      mon_e.cnt  = bump_count;
      mon_e.vars = bump_vars;
      obs_q.push_back(mon_e);
      obs_cyc_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: split legal literals into chunks of 8, then one decay per clause.
  task automatic model_clause(input logic [31:0] q[$], input logic [31:0] mx);
    ev_t cur;
    int  n;
    bit  dup;
    cur = '0;
    n   = 0;
    foreach (q[i]) begin
      if (q[i] == 32'd0 || q[i] > mx) begin
        exp_drops++;
        continue;
      end
      dup = 1'b0;
      if (DEDUP) for (int j = 0; j < n; j++) if (cur.vars[j] == q[i]) dup = 1'b1;
      if (dup) continue;
      cur.vars[n] = q[i];
      n++;
      if (n == 8) begin
        cur.cnt = 4'd8;
        exp_q.push_back(cur);
        cur = '0;
        n   = 0;
      end
    end
    if (n > 0) begin
      cur.cnt = 4'(n);
      exp_q.push_back(cur);
    end
    cur     = '0;
    cur.dec = 1'b1;
    exp_q.push_back(cur);
  endtask

  task automatic send(input logic [31:0] v, input logic last);
    int   w;
    logic rdy;
    w   = 0;
    rdy = 1'b0;
    lit_valid = 1'b1;
    lit_var   = v;
    lit_last  = last;
    while (!rdy && w < 200) begin
      @(negedge clk);
      rdy     = lit_ready;
      acc_cyc = cyc;
      @(posedge clk);
      #1;
      w++;
    end
    lit_valid = 1'b0;
    lit_last  = 1'b0;
    lit_var   = 32'd0;
    if (!rdy) check("send_timeout", 0, 1);
  endtask

  task automatic send_clause(input logic [31:0] q[$], input int max_gap);
    @(posedge clk);
    #1;
    foreach (q[i]) begin
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) begin
        @(posedge clk);
        #1;
      end
      send(q[i], i == q.size() - 1);
    end
  endtask

  task automatic wait_obs(input int need);
    int w;
    w = 0;
    while (obs_q.size() < need && w < 2000) begin
      @(negedge clk);
      w++;
    end
  endtask

  task automatic drain_compare(input string tag);
    ev_t e;
    ev_t o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_obs(1);
      if (obs_q.size() == 0) begin
        check({tag, "_event_timeout"}, 0, 1);
        exp_q.delete();
        return;
      end
      o = obs_q.pop_front();
      void'(obs_cyc_q.pop_front());
      check({tag, "_kind"}, o.dec, e.dec);
      check({tag, "_count"}, o.cnt, e.cnt);
      check({tag, "_vars"}, o.vars, e.vars);
    end
    repeat (5) @(negedge clk);
    check({tag, "_extra_events"}, obs_q.size(), 0);
    obs_q.delete();
    obs_cyc_q.delete();
  endtask

  logic [31:0] q[$];
  int          t_acc;
  int          lowcnt;
  int          w;
  logic        bad;
  logic [15:0] d0;
  bit          rnd_done;

  initial begin
    reset = 1'b1; clear_all = 1'b0; lit_valid = 1'b0; lit_var = 32'd0; lit_last = 1'b0;
    bump_ready = 1'b1; max_var = 32'd256;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_lit_ready", lit_ready, 1);
    check("rst_bump_count", bump_count, 0);
    check("rst_bump_vars", bump_vars, 0);
    check("rst_decay", decay, 0);
    check("rst_busy", busy, 0);
    check("rst_drop_cnt", drop_cnt, 0);

    // Short clause: batch at t+1, decay at t+2, two not-ready cycles.
    q = '{32'd5, 32'd9, 32'd12};
    model_clause(q, 32'd256);
    send_clause(q, 0);
    t_acc  = acc_cyc;
    lowcnt = 0;
    w      = 0;
    while (w < 20) begin
      @(negedge clk);
      w++;
      if (lit_ready) break;
      lowcnt++;
    end
    check("t1_ready_low_cycles", lowcnt, 2);
    wait_obs(2);
    if (obs_q.size() >= 2) begin
      check("t1_batch_cycle", obs_cyc_q[0], t_acc + 1);
      check("t1_decay_cycle", obs_cyc_q[1], t_acc + 2);
      check("t1_batch_count", obs_q[0].cnt, 3);
      check("t1_batch_vars", obs_q[0].vars, {160'd0, 32'd12, 32'd9, 32'd5});
    end else check("t1_events_seen", obs_q.size(), 2);
    drain_compare("t1");

    // Overflowing clause splits into 8 + 3 with one trailing decay.
    q.delete();
    for (int k = 1; k <= 11; k++) q.push_back(32'(k));
    model_clause(q, 32'd256);
    send_clause(q, 0);
    drain_compare("t2");

    // Illegal literals only: no batch, decay still follows.
    q = '{32'd0, 32'd300};
    model_clause(q, 32'd256);
    send_clause(q, 0);
    drain_compare("t3");
    check("t3_drop_cnt", drop_cnt, 2);

    // Downstream stall holds the batch intact.
    bump_ready = 1'b0;
    q = '{32'd21, 32'd22, 32'd23, 32'd24, 32'd25};
    model_clause(q, 32'd256);
    send_clause(q, 0);
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bump_count != 4'd0 || lit_ready || decay) bad = 1'b1;
    end
    check("t4_stall_quiet", bad, 0);
    check("t4_stall_no_events", obs_q.size(), 0);
    bump_ready = 1'b1;
    drain_compare("t4");

    // Flush while a 4-entry batch waits in EMIT.
    bump_ready = 1'b0;
    q = '{32'd31, 32'd32, 32'd33, 32'd34};
    send_clause(q, 0);
    d0 = drop_cnt;
    @(posedge clk);
    #1 clear_all = 1'b1;
    bump_ready = 1'b1;
    @(negedge clk);
    check("t5_clr_bump_count", bump_count, 0);
    check("t5_clr_decay", decay, 0);
    check("t5_clr_lit_ready", lit_ready, 0);
    @(posedge clk);
    #1 clear_all = 1'b0;
    @(negedge clk);
    check("t5_post_lit_ready", lit_ready, 1);
    check("t5_post_busy", busy, 0);
    check("t5_post_drop_cnt", drop_cnt, d0);
    repeat (6) @(negedge clk);
    check("t5_no_events", obs_q.size(), 0);
    obs_q.delete();
    obs_cyc_q.delete();

    // Repeated variable inside one batch.
    q = '{32'd7, 32'd7, 32'd3};
    model_clause(q, 32'd256);
    send_clause(q, 0);
    wait_obs(1);
    if (obs_q.size() >= 1) begin
      check("t6_count", obs_q[0].cnt, DEDUP ? 4'd2 : 4'd3);
      check("t6_vars", obs_q[0].vars, DEDUP ? {192'd0, 32'd3, 32'd7} : {160'd0, 32'd3, 32'd7, 32'd7});
    end else check("t6_event_seen", obs_q.size(), 1);
    drain_compare("t6");
    check("t6_drop_cnt", drop_cnt, 16'(exp_drops));

    // Random clauses, gaps and downstream back-pressure.
    max_var  = 32'($urandom_range(20, 60));
    rnd_done = 1'b0;
    fork
      begin
        for (int c = 0; c < 30; c++) begin
          q.delete();
          for (int k = 0; k < $urandom_range(1, 20); k++) q.push_back(32'($urandom_range(0, 70)));
          model_clause(q, max_var);
          send_clause(q, 2);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 bump_ready = ($urandom_range(0, 3) != 0);
        end
        bump_ready = 1'b1;
      end
    join
    drain_compare("rnd");
    check("rnd_drop_cnt", drop_cnt, 16'(exp_drops));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vde_bump_packer.md
# vde_bump_packer

Packs the literal stream of a freshly learned clause into the multi-bump batches and the decay pulse consumed by the `vde` decision engine. Sits directly upstream of `vde`, between conflict analysis and the VDE multi-bump/decay ports. It accepts one variable per cycle, filters and optionally de-duplicates variables, and emits at most 8 variables per batch. Batches are paced by a downstream-ready signal, so the VDE single-entry multi-bump holding register is never overwritten.

## Interface

Parameters:
- `BATCH` (default 8): variables per batch. Fixed by the `vde` port width; legal range 1..8.
- `DROP_W` (default 16): width of the saturating dropped-literal counter.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-high.
- `clear_all`, in, 1: synchronous flush (solver restart).
- `max_var`, in, 32: highest legal variable index.
- `lit_valid`, in, 1: literal offered.
- `lit_ready`, out, 1: literal accepted when `lit_valid && lit_ready`.
- `lit_var`, in, 32: variable index; sign already stripped.
- `lit_last`, in, 1: marks the final literal of the clause.
- `bump_ready`, in, 1: downstream can take a batch or decay pulse.
- `bump_count`, out, 4: number of valid variables in this cycle's batch; 0 means none.
- `bump_vars`, out, 8x32: batch variables, packed from slot 0; unused slots are 0.
- `decay`, out, 1: one-cycle activity-decay pulse.
- `busy`, out, 1: high whenever state ≠ COLLECT or the batch is non-empty.
- `drop_cnt`, out, DROP_W: saturating count of rejected literals.

## Operation

- FSM states: COLLECT, EMIT, DECAY. Reset state is COLLECT.
- COLLECT:
  - `lit_ready` = 1.
  - An accepted literal with `lit_var == 0` or `lit_var > max_var` is rejected, and `drop_cnt` increments (saturates at all-ones).
  - A legal literal is written to slot `n`, then `n++`.
  - If `n` reaches `BATCH` → EMIT.
  - If `lit_last` is set: go to EMIT when the batch is non-empty after this literal; otherwise go straight to DECAY. A `pending_decay` flag is set.
- EMIT:
  - `lit_ready` = 0. The FSM waits for `bump_ready`.
  - When `bump_ready` is high: `bump_count = n` and `bump_vars` = batch for exactly that cycle. Next cycle `n` = 0 and the batch is zeroed.
  - Next state is DECAY if `pending_decay` is set, else COLLECT.
- DECAY:
  - `lit_ready` = 0. The FSM waits for `bump_ready`.
  - When `bump_ready` is high, `decay` = 1 for one cycle. Then `pending_decay` is cleared and the state returns to COLLECT.
- Overflow: a clause longer than `BATCH` produces several batches. Decay follows only the last batch.
- `clear_all` (highest priority, any state):
  - Next state COLLECT, `n` = 0, batch zeroed, `pending_decay` = 0.
  - `lit_ready`, `bump_count` and `decay` are forced to 0 in that cycle.
  - `drop_cnt` is preserved.
- Reset values: state COLLECT, `n` 0, batch 0, `pending_decay` 0, `drop_cnt` 0. Outputs are `lit_ready` 1 and all others 0.

## Timing

- `bump_count`, `bump_vars`, `decay` and `lit_ready` are combinational decodes of registered state, gated by `bump_ready` and `clear_all`. There is no input→output combinational path other than those two gates.
- Literal accepted at cycle t that fills the batch or is `lit_last` → batch visible at t+1 if `bump_ready`. Decay visible at t+2 at the earliest.
- Steady-state throughput is `BATCH` literals per `BATCH`+1 cycles. Each clause adds one extra cycle for decay.
- A `bump_ready` stall holds the state indefinitely. Outputs stay 0 during the stall, and nothing is lost.

## Configuration

- `VDE_BUMP_DEDUP_EN` defined:
  - A legal literal whose `lit_var` equals any occupied slot of the current batch is dropped silently; `drop_cnt` does not change.
  - Duplicate detection uses a parallel compare against `n` slots.
  - Duplicates across batch boundaries are not detected.
- Undefined: duplicates are stored and emitted as-is.

## Structure

- Package `vde_pkg` holds:
  - `VDE_BATCH_MAX` = 8
  - `VDE_CNT_W` = 4
  - the state enum `bump_pack_state_e`
- `vde` references `VDE_BATCH_MAX` and `VDE_CNT_W` for its port widths.
- Single flat module; no sub-module is warranted.

## Test plan

- Three-literal clause 5, 9, 12 (last on 12), `bump_ready` = 1 → one cycle with `bump_count` = 3, vars {5, 9, 12, 0…}; `decay` pulses the next cycle; `lit_ready` low for exactly 2 cycles.
- Eleven-literal clause 1..11 → batch 1..8 (count 8), then batch 9..11 (count 3), then a single `decay` pulse. No decay between the two batches.
- `lit_var` 0 and 300 with `max_var` = 256, with 300 as `lit_last`; `lit_var` 0 is not the last literal → no batch, `decay` still pulses, `drop_cnt` = 2.
- Hold `bump_ready` = 0 for 10 cycles while in EMIT → `bump_count` stays 0 and `lit_ready` stays 0. Releasing `bump_ready` emits the original batch unchanged.
- `clear_all` asserted in EMIT with `n` = 4 → no batch and no decay; next cycle `lit_ready` = 1, `busy` = 0, `drop_cnt` unchanged.
- With `VDE_BUMP_DEDUP_EN`: clause 7, 7, 3 (last on 3) → `bump_count` = 2, vars {7, 3}, `drop_cnt` unchanged. Without the macro → `bump_count` = 3, vars {7, 7, 3}.
